// File: rtl/ddr5_cmd_sequencer.sv
// DDR5 command sequencer: in-order request queue, open-page bank tracking,
// two-cycle ACT/RD/WR command issue with tRCD/tRP/tRFC spacing and periodic refresh.
module ddr5_cmd_sequencer #(
    parameter int QUEUE_DEPTH = 16,
    parameter int NUM_BANKS   = 32,
    parameter int ROW_W       = 16,
    parameter int COL_W       = 11,
    parameter int CORE_W      = 4,
    parameter int T_RCD       = 39,
    parameter int T_RP        = 39,
    parameter int T_RFC       = 708,
    parameter int T_REFI      = 9360
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [CORE_W-1:0]                req_core,
    input  logic [$clog2(NUM_BANKS)-1:0]     req_bank,
    input  logic [ROW_W-1:0]                 req_row,
    input  logic [COL_W-1:0]                 req_col,
    output logic                             cmd_valid,
    output logic [3:0]                       cmd,
    output logic [$clog2(NUM_BANKS)-1:0]     cmd_bank,
    output logic [ROW_W-1:0]                 cmd_addr,
    output logic                             done_valid,
    output logic [CORE_W-1:0]                done_core,
    output logic                             done_write,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
    output logic                             refresh_busy
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int REFI_W = $clog2(T_REFI + 1);
    localparam int T_MAX  = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                            : ((T_RCD > T_RP) ? T_RCD : T_RP);
    localparam int WAIT_W = $clog2(T_MAX + 1);

    // Wait-state reload values: the issuing state and the exit transition
    // account for the remaining cycles of each spacing constraint.
    localparam logic [WAIT_W-1:0] RCD_LOAD = WAIT_W'(T_RCD - 3);
    localparam logic [WAIT_W-1:0] RP_LOAD  = WAIT_W'(T_RP - 2);
    localparam logic [WAIT_W-1:0] RFC_LOAD = WAIT_W'((T_RFC > 3) ? (T_RFC - 3) : 0);

    localparam logic [3:0] CMD_NOP  = 4'd0;
    localparam logic [3:0] CMD_ACT0 = 4'd1;
    localparam logic [3:0] CMD_ACT1 = 4'd2;
    localparam logic [3:0] CMD_RD0  = 4'd3;
    localparam logic [3:0] CMD_RD1  = 4'd4;
    localparam logic [3:0] CMD_WR0  = 4'd5;
    localparam logic [3:0] CMD_WR1  = 4'd6;
    localparam logic [3:0] CMD_PRE  = 4'd7;
    localparam logic [3:0] CMD_PREA = 4'd8;
    localparam logic [3:0] CMD_REF  = 4'd9;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_PRE       = 4'd1;
    localparam logic [3:0] S_PRE_WAIT  = 4'd2;
    localparam logic [3:0] S_ACT0      = 4'd3;
    localparam logic [3:0] S_ACT1      = 4'd4;
    localparam logic [3:0] S_RCD_WAIT  = 4'd5;
    localparam logic [3:0] S_CAS0      = 4'd6;
    localparam logic [3:0] S_CAS1      = 4'd7;
    localparam logic [3:0] S_PREA      = 4'd8;
    localparam logic [3:0] S_PREA_WAIT = 4'd9;
    localparam logic [3:0] S_REF       = 4'd10;
    localparam logic [3:0] S_RFC_WAIT  = 4'd11;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QUEUE_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    logic              q_write [QUEUE_DEPTH];
    logic [CORE_W-1:0] q_core  [QUEUE_DEPTH];
    logic [BANK_W-1:0] q_bank  [QUEUE_DEPTH];
    logic [ROW_W-1:0]  q_row   [QUEUE_DEPTH];
    logic [COL_W-1:0]  q_col   [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_W-1:0]     bank_row [NUM_BANKS];

    logic [REFI_W-1:0] refi_cnt;
    logic              ref_pending;

    logic [3:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;

    logic [3:0]        cmd_nxt;
    logic [BANK_W-1:0] bank_nxt;
    logic [ROW_W-1:0]  addr_nxt;

    logic              push, pop;
    logic              head_write;
    logic [CORE_W-1:0] head_core;
    logic [BANK_W-1:0] head_bank;
    logic [ROW_W-1:0]  head_row;
    logic [COL_W-1:0]  head_col;
    logic              head_open, head_hit, any_open;

    assign req_ready   = (count < CNT_W'(QUEUE_DEPTH));
    assign queue_count = count;
    assign push        = req_valid && req_ready;
    // The head retires on the transition into CAS1.
    assign pop         = (state == S_CAS0);

    assign head_write = q_write[rd_ptr];
    assign head_core  = q_core[rd_ptr];
    assign head_bank  = q_bank[rd_ptr];
    assign head_row   = q_row[rd_ptr];
    assign head_col   = q_col[rd_ptr];
    assign head_open  = bank_open[head_bank];
    assign head_hit   = head_open && (bank_row[head_bank] == head_row);
    assign any_open   = |bank_open;

    assign refresh_busy = (state == S_PREA) || (state == S_PREA_WAIT) ||
                          (state == S_REF)  || (state == S_RFC_WAIT);

    always_ff @(posedge clock) begin
        if (push) begin
            q_write[wr_ptr] <= req_write;
            q_core[wr_ptr]  <= req_core;
            q_bank[wr_ptr]  <= req_bank;
            q_row[wr_ptr]   <= req_row;
            q_col[wr_ptr]   <= req_col;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // An expiry coinciding with REF stays pending so no interval is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            refi_cnt    <= REFI_W'(T_REFI);
            ref_pending <= 1'b0;
        end else begin
            if (state_nxt == S_REF) ref_pending <= 1'b0;
            if (refi_cnt == '0) begin
                refi_cnt    <= REFI_W'(T_REFI - 1);
                ref_pending <= 1'b1;
            end else begin
                refi_cnt <= refi_cnt - REFI_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_nxt == S_ACT0) bank_row[head_bank] <= head_row;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_open <= '0;
        end else if (state_nxt == S_REF) begin
            bank_open <= '0;
        end else if (state_nxt == S_PRE) begin
            bank_open[head_bank] <= 1'b0;
        end else if (state_nxt == S_ACT0) begin
            bank_open[head_bank] <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (ref_pending) begin
                    state_nxt = any_open ? S_PREA : S_REF;
                end else if (count != '0) begin
                    if (head_hit)       state_nxt = S_CAS0;
                    else if (head_open) state_nxt = S_PRE;
                    else                state_nxt = S_ACT0;
                end
            end
            S_PRE: begin
                state_nxt = S_PRE_WAIT;
                wait_nxt  = RP_LOAD;
            end
            S_PRE_WAIT: begin
                if (wait_cnt == '0) state_nxt = S_ACT0;
                else                wait_nxt  = wait_cnt - WAIT_W'(1);
            end
            S_ACT0: state_nxt = S_ACT1;
            S_ACT1: begin
                state_nxt = S_RCD_WAIT;
                wait_nxt  = RCD_LOAD;
            end
            S_RCD_WAIT: begin
                if (wait_cnt == '0) state_nxt = S_CAS0;
                else                wait_nxt  = wait_cnt - WAIT_W'(1);
            end
            S_CAS0: state_nxt = S_CAS1;
            S_CAS1: state_nxt = S_IDLE;
            S_PREA: begin
                state_nxt = S_PREA_WAIT;
                wait_nxt  = RP_LOAD;
            end
            S_PREA_WAIT: begin
                if (wait_cnt == '0) state_nxt = S_REF;
                else                wait_nxt  = wait_cnt - WAIT_W'(1);
            end
            S_REF: begin
                state_nxt = S_RFC_WAIT;
                wait_nxt  = RFC_LOAD;
            end
            S_RFC_WAIT: begin
                if (wait_cnt == '0) state_nxt = S_IDLE;
                else                wait_nxt  = wait_cnt - WAIT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Commands are decoded from the state being entered and registered with it.
    always_comb begin
        cmd_nxt  = CMD_NOP;
        bank_nxt = '0;
        addr_nxt = '0;
        case (state_nxt)
            S_ACT0: begin
                cmd_nxt  = CMD_ACT0;
                bank_nxt = head_bank;
                addr_nxt = head_row;
            end
            S_ACT1: begin
                cmd_nxt  = CMD_ACT1;
                bank_nxt = head_bank;
                addr_nxt = head_row;
            end
            S_CAS0: begin
                cmd_nxt  = head_write ? CMD_WR0 : CMD_RD0;
                bank_nxt = head_bank;
                addr_nxt = ROW_W'(head_col);
            end
            S_CAS1: begin
                cmd_nxt  = head_write ? CMD_WR1 : CMD_RD1;
                bank_nxt = head_bank;
                addr_nxt = ROW_W'(head_col);
            end
            S_PRE: begin
                cmd_nxt  = CMD_PRE;
                bank_nxt = head_bank;
            end
            S_PREA:  cmd_nxt = CMD_PREA;
            S_REF:   cmd_nxt = CMD_REF;
            default: cmd_nxt = CMD_NOP;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid  <= 1'b0;
            cmd        <= CMD_NOP;
            cmd_bank   <= '0;
            cmd_addr   <= '0;
            done_valid <= 1'b0;
            done_core  <= '0;
            done_write <= 1'b0;
        end else begin
            cmd_valid  <= (cmd_nxt != CMD_NOP);
            cmd        <= cmd_nxt;
            cmd_bank   <= bank_nxt;
            cmd_addr   <= addr_nxt;
            done_valid <= pop;
            done_core  <= pop ? head_core : '0;
            done_write <= pop && head_write;
        end
    end

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Bench for ddr5_cmd_sequencer: per-cycle vector table for read/write/hit/miss
// traffic, plus hand-written refresh, queue-full and mid-sequence reset sequences.
module tb_ddr5_cmd_sequencer;

    localparam int C_NOP = 0, C_ACT0 = 1, C_ACT1 = 2, C_RD0 = 3, C_RD1 = 4;
    localparam int C_WR0 = 5, C_WR1 = 6, C_PRE = 7, C_PREA = 8, C_REF = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_core;
    logic [4:0]  req_bank;
    logic [15:0] req_row;
    logic [10:0] req_col;
    logic        cmd_valid, done_valid, done_write, refresh_busy;
    logic [3:0]  cmd, done_core;
    logic [4:0]  cmd_bank, queue_count;
    logic [15:0] cmd_addr;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [3:0]  b_req_core;
    logic [4:0]  b_req_bank;
    logic [15:0] b_req_row;
    logic [10:0] b_req_col;
    logic        b_cmd_valid, b_done_valid, b_done_write, b_refresh_busy;
    logic [3:0]  b_cmd, b_done_core;
    logic [4:0]  b_cmd_bank, b_queue_count;
    logic [15:0] b_cmd_addr;

    ddr5_cmd_sequencer #(.T_RCD(4), .T_RP(3), .T_RFC(6), .T_REFI(200)) dut (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_core(req_core), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
        .done_valid(done_valid), .done_core(done_core), .done_write(done_write),
        .queue_count(queue_count), .refresh_busy(refresh_busy)
    );

    // Default (long) timing so the queue can fill before the first request retires.
    ddr5_cmd_sequencer dut_big (
        .clock(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_core(b_req_core), .req_bank(b_req_bank), .req_row(b_req_row), .req_col(b_req_col),
        .cmd_valid(b_cmd_valid), .cmd(b_cmd), .cmd_bank(b_cmd_bank), .cmd_addr(b_cmd_addr),
        .done_valid(b_done_valid), .done_core(b_done_core), .done_write(b_done_write),
        .queue_count(b_queue_count), .refresh_busy(b_refresh_busy)
    );

    typedef struct {
        logic        vld;
        logic        wr;
        logic [3:0]  core;
        logic [4:0]  bank;
        logic [15:0] row;
        logic [10:0] col;
        logic [3:0]  ecmd;
        logic [4:0]  ebank;
        logic [15:0] eaddr;
        logic        edone;
        logic [3:0]  ecore;
        logic        ewr;
        logic [4:0]  ecnt;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int vld, wr, core, bank, row, col,
                                input int ecmd, ebank, eaddr, edone, ecore, ewr, ecnt);
        vec_t v;
        v.vld = vld[0];     v.wr = wr[0];       v.core = core[3:0];
        v.bank = bank[4:0]; v.row = row[15:0];  v.col = col[10:0];
        v.ecmd = ecmd[3:0]; v.ebank = ebank[4:0]; v.eaddr = eaddr[15:0];
        v.edone = edone[0]; v.ecore = ecore[3:0]; v.ewr = ewr[0]; v.ecnt = ecnt[4:0];
        return v;
    endfunction

    function automatic vec_t nv(input int ecmd, ebank, eaddr, ecnt);
        return mk(0, 0, 0, 0, 0, 0, ecmd, ebank, eaddr, 0, 0, 0, ecnt);
    endfunction

    task automatic drive_main(input logic vld, input logic wr, input logic [3:0] core,
                              input logic [4:0] bank, input logic [15:0] row, input logic [10:0] col);
        req_valid = vld; req_write = wr; req_core = core;
        req_bank = bank; req_row = row;  req_col = col;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, 32'(cmd), 32'(C_NOP));
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_cmd_bank"}, 32'(cmd_bank), 32'd0);
        check({tag, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
        check({tag, "_queue_count"}, 32'(queue_count), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_done_valid"}, 32'(done_valid), 32'd0);
        check({tag, "_refresh_busy"}, 32'(refresh_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int n, drop_n, done_cyc, acc17_cyc, maxcnt;
        int exp_cmd;

        drive_main(0, 0, 0, 0, 0, 0);
        b_req_valid = 0; b_req_write = 0; b_req_core = 0;
        b_req_bank = 0;  b_req_row = 0;   b_req_col = 0;
        reset_n = 0;
        #12;
        check_reset_outputs("por");
        check("por_big_ready", 32'(b_req_ready), 32'd1);

        // cycle-by-cycle table: closed read, row-hit write, row-miss read, two queued hits
        vecs.push_back(mk(1, 0, 3, 2, 'h10, 'h5, C_NOP, 0, 0, 0, 0, 0, 0));  // 0
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_ACT0, 2, 'h10, 1));
        vecs.push_back(nv(C_ACT1, 2, 'h10, 1));
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_RD0, 2, 'h5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, C_RD1, 2, 'h5, 1, 3, 0, 0));     // 7
        vecs.push_back(mk(1, 1, 5, 2, 'h10, 'h8, C_NOP, 0, 0, 0, 0, 0, 0));  // 8
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_WR0, 2, 'h8, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, C_WR1, 2, 'h8, 1, 5, 1, 0));     // 11
        vecs.push_back(mk(1, 0, 7, 2, 'h20, 'h3, C_NOP, 0, 0, 0, 0, 0, 0));  // 12
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_PRE, 2, 0, 1));                                  // 14 = p
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_ACT0, 2, 'h20, 1));                              // p+3
        vecs.push_back(nv(C_ACT1, 2, 'h20, 1));
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_RD0, 2, 'h3, 1));                                // p+7
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, C_RD1, 2, 'h3, 1, 7, 0, 0));     // 22
        vecs.push_back(mk(1, 0, 1, 2, 'h20, 'h10, C_NOP, 0, 0, 0, 0, 0, 0)); // 23
        vecs.push_back(mk(1, 1, 2, 2, 'h20, 'h11, C_NOP, 0, 0, 0, 0, 0, 1)); // 24
        vecs.push_back(nv(C_RD0, 2, 'h10, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, C_RD1, 2, 'h10, 1, 1, 0, 1));    // 26
        vecs.push_back(nv(C_NOP, 0, 0, 1));
        vecs.push_back(nv(C_WR0, 2, 'h11, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, C_WR1, 2, 'h11, 1, 2, 1, 0));    // 29
        vecs.push_back(nv(C_NOP, 0, 0, 0));

        @(negedge clk);
        reset_n = 1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive_main(vecs[i].vld, vecs[i].wr, vecs[i].core, vecs[i].bank, vecs[i].row, vecs[i].col);
            check($sformatf("cmd[%0d]", i), 32'(cmd), 32'(vecs[i].ecmd));
            check($sformatf("cmd_valid[%0d]", i), 32'(cmd_valid), 32'(vecs[i].ecmd != 4'd0));
            check($sformatf("cmd_bank[%0d]", i), 32'(cmd_bank), 32'(vecs[i].ebank));
            check($sformatf("cmd_addr[%0d]", i), 32'(cmd_addr), 32'(vecs[i].eaddr));
            check($sformatf("done_valid[%0d]", i), 32'(done_valid), 32'(vecs[i].edone));
            check($sformatf("queue_count[%0d]", i), 32'(queue_count), 32'(vecs[i].ecnt));
            check($sformatf("req_ready[%0d]", i), 32'(req_ready), 32'd1);
            if (vecs[i].edone) begin
                check($sformatf("done_core[%0d]", i), 32'(done_core), 32'(vecs[i].ecore));
                check($sformatf("done_write[%0d]", i), 32'(done_write), 32'(vecs[i].ewr));
            end
            step();
        end
        drive_main(0, 0, 0, 0, 0, 0);

        // refresh with bank 2 open: PREA, REF after tRP, busy through tRFC, then ACT0
        found = 0;
        for (int t = 0; t < 400 && found == 0; t++) begin
            if (cmd == 4'(C_PREA)) found = 1;
            else step();
        end
        check("prea_seen", 32'(found), 32'd1);
        if (found == 1) begin
            for (int j = 0; j <= 9; j++) begin
                if (j == 1) drive_main(1, 0, 4, 2, 'h20, 'h9);
                else        drive_main(0, 0, 0, 0, 0, 0);
                exp_cmd = (j == 0) ? C_PREA : (j == 3) ? C_REF : (j == 9) ? C_ACT0 : C_NOP;
                check($sformatf("refresh_cmd[p+%0d]", j), 32'(cmd), 32'(exp_cmd));
                check($sformatf("refresh_busy[p+%0d]", j), 32'(refresh_busy), 32'(j <= 7));
                if (j == 9) begin
                    check("post_refresh_act_bank", 32'(cmd_bank), 32'd2);
                    check("post_refresh_act_row", 32'(cmd_addr), 32'h20);
                end
                step();
            end
            found = 0;
            for (int t = 0; t < 20 && found == 0; t++) begin
                if (done_valid) found = 1;
                else step();
            end
            check("post_refresh_done", 32'(found), 32'd1);
            check("post_refresh_done_core", 32'(done_core), 32'd4);
        end

        // queue-full behaviour on the long-timing instance
        @(negedge clk);
        reset_n = 0;
        #2;
        @(negedge clk);
        reset_n = 1;
        step();
        n = 0; drop_n = -1; done_cyc = -1; acc17_cyc = -1; maxcnt = 0;
        for (int c = 0; c < 300 && n < 17; c++) begin
            b_req_valid = 1'b1; b_req_write = 1'b0; b_req_core = 4'(n);
            b_req_bank = 5'd1;  b_req_row = 16'h7;  b_req_col = 11'(n);
            if (b_done_valid && done_cyc < 0) done_cyc = c;
            if (int'(b_queue_count) > maxcnt) maxcnt = int'(b_queue_count);
            if (!b_req_ready && drop_n < 0) drop_n = n;
            if (b_req_ready) begin
                if (n == 16) acc17_cyc = c;
                n++;
            end
            step();
        end
        b_req_valid = 1'b0;
        check("fill_accepted", 32'(n), 32'd17);
        check("fill_ready_drop_after", 32'(drop_n), 32'd16);
        check("fill_first_done_seen", 32'(done_cyc >= 0), 32'd1);
        check("fill_17th_at_done", 32'(acc17_cyc), 32'(done_cyc));
        check("fill_count_after", 32'(b_queue_count), 32'd16);
        if (int'(b_queue_count) > maxcnt) maxcnt = int'(b_queue_count);
        check("fill_max_count", 32'(maxcnt), 32'd16);

        // refresh with every bank closed goes straight to REF
        found = 0;
        for (int t = 0; t < 400 && found == 0; t++) begin
            if (cmd != 4'(C_NOP)) found = 1;
            else step();
        end
        check("closed_refresh_cmd_seen", 32'(found), 32'd1);
        if (found == 1) begin
            for (int j = 0; j <= 5; j++) begin
                check($sformatf("closed_refresh_cmd[r+%0d]", j), 32'(cmd), 32'((j == 0) ? C_REF : C_NOP));
                check($sformatf("closed_refresh_busy[r+%0d]", j), 32'(refresh_busy), 32'(j <= 4));
                step();
            end
        end

        // asynchronous reset in RCD_WAIT with three requests queued
        for (int j = 0; j < 4; j++) begin
            if (j < 3) drive_main(1, 0, 4'(j), 5'(4 + j), 16'(1 + j), 11'h2);
            else       drive_main(0, 0, 0, 0, 0, 0);
            if (j == 2) begin
                check("mid_act0_cmd", 32'(cmd), 32'(C_ACT0));
                check("mid_act0_bank", 32'(cmd_bank), 32'd4);
            end
            step();
        end
        check("mid_rcd_wait_cmd", 32'(cmd), 32'(C_NOP));
        check("mid_queue_count", 32'(queue_count), 32'd3);
        reset_n = 0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        check("mid_reset_no_done", 32'(done_valid), 32'd0);
        @(negedge clk);
        reset_n = 1;
        step();
        drive_main(1, 0, 9, 4, 'h1, 'h2);
        step();
        drive_main(0, 0, 0, 0, 0, 0);
        check("after_reset_count", 32'(queue_count), 32'd1);
        step();
        check("after_reset_cmd", 32'(cmd), 32'(C_ACT0));
        check("after_reset_bank", 32'(cmd_bank), 32'd4);
        check("after_reset_row", 32'(cmd_addr), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr5_cmd_sequencer.md
# ddr5_cmd_sequencer

Synthesizable, parametrised DDR5 command sequencer for the memory scheduler. It buffers pre-mapped CPU requests in an in-order queue and tracks the open row of every bank with an open-page policy. It issues two-cycle DDR5 commands (ACT0/ACT1, RD0/RD1, WR0/WR1, PRE, PREA, REF) under tRCD/tRP/tRFC spacing and inserts periodic refresh. It sits between the address-mapping stage and the DIMM command bus model.

## Interface
- QUEUE_DEPTH, 16, request queue entries (≥2)
- NUM_BANKS, 32, banks tracked (bank group × bank, power of 2)
- ROW_W, 16, row address width
- COL_W, 11, column address width
- CORE_W, 4, core ID width
- T_RCD, 39, cycles from ACT0 to RD0/WR0 (≥3)
- T_RP, 39, cycles from PRE/PREA to the next ACT0/REF (≥2)
- T_RFC, 708, cycles from REF to the next command (≥2)
- T_REFI, 9360, refresh interval in cycles (> T_RFC)

Ports:
- clock  in  1  sequencer clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  queue not full; push occurs when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_core  in  CORE_W  originating core
- req_bank  in  $clog2(NUM_BANKS)  target bank
- req_row  in  ROW_W  target row
- req_col  in  COL_W  target column
- cmd_valid  out  1  command on the bus this cycle
- cmd  out  4  NOP=0, ACT0=1, ACT1=2, RD0=3, RD1=4, WR0=5, WR1=6, PRE=7, PREA=8, REF=9
- cmd_bank  out  $clog2(NUM_BANKS)  bank for ACT/RD/WR/PRE; 0 otherwise
- cmd_addr  out  ROW_W  row for ACT0/ACT1; zero-extended column for RD/WR; 0 otherwise
- done_valid  out  1  one-cycle pulse: head request fully issued and popped
- done_core  out  CORE_W  core of the completed request
- done_write  out  1  type of the completed request
- queue_count  out  $clog2(QUEUE_DEPTH+1)  occupancy
- refresh_busy  out  1  refresh sequence in progress (PREA through tRFC)

## Operation
- Reset values: queue empty, queue_count 0, req_ready 1, cmd_valid 0, cmd NOP, cmd_bank/cmd_addr 0, done_* 0, refresh_busy 0, all banks closed, FSM IDLE, refresh timer loaded with T_REFI, ref_pending 0.
- Queue: circular FIFO; req_ready = (queue_count < QUEUE_DEPTH). A push and a pop in the same cycle leave the count unchanged. A push when full is impossible because ready is low.
- Refresh timer decrements every cycle. At 0 it sets ref_pending and reloads. A second expiry while pending is absorbed (no postponement count).
- FSM states: IDLE, PRE, PRE_WAIT, ACT0, ACT1, RCD_WAIT, CAS0, CAS1, PREA, PREA_WAIT, REF, RFC_WAIT.
- IDLE priority: ref_pending first, then the queue head.
- Refresh path: if any bank is open, IDLE→PREA→PREA_WAIT→REF; otherwise IDLE→REF directly. REF→RFC_WAIT→IDLE. At REF, clear ref_pending and mark all banks closed. Refresh never interrupts an in-flight request.
- Head request, bank closed: IDLE→ACT0→ACT1→RCD_WAIT→CAS0→CAS1→IDLE.
- Head request, row hit: IDLE→CAS0→CAS1→IDLE.
- Head request, row miss: IDLE→PRE→PRE_WAIT→ACT0→…; at PRE, mark the bank closed.
- CAS0/CAS1 issue RD0/RD1 or WR0/WR1 per req_write.
- In CAS1, pop the head, pulse done_valid with the head's core and type, and leave the bank open with the new row recorded at ACT0.
- Each FSM state is entered for exactly one cycle except the wait states.

## Timing
- Command outputs are registered; cmd_valid=1 exactly in cycles with cmd≠NOP.
- Accept edge k into an empty, idle sequencer: entry visible at k+1, first command on the bus at k+2.
- Closed bank, ACT0 at cycle a: ACT1 at a+1, RD0/WR0 at a+T_RCD, RD1/WR1 and done_valid at a+T_RCD+1.
- Row hit: CAS0 at k+2, CAS1/done at k+3. Back-to-back hits give one CAS pair every 3 cycles (IDLE, CAS0, CAS1).
- PRE or PREA at cycle p: next ACT0 or REF no earlier than p+T_RP, and exactly p+T_RP when pending.
- REF at r: next command no earlier than r+T_RFC.
- reset_n low mid-sequence: every output returns to its reset value immediately (asynchronously). The queue is flushed, no done pulse is generated, and all banks are treated as closed.

## Test plan
- Overrides T_RCD=4, T_RP=3, T_RFC=6, T_REFI=200. Read bank 2, row 0x10, col 0x5, accepted at cycle 0 → ACT0/ACT1 at 2/3 (addr 0x10), RD0/RD1 at 6/7 (addr 0x5), done at 7, queue_count back to 0.
- Then write bank 2, row 0x10, col 0x8 (row hit) → WR0/WR1 two and three cycles after accept, no ACT, done_write=1.
- Then read bank 2, row 0x20 (row miss) → PRE bank 2 at p, ACT0 at p+3, RD0 at p+7.
- Push 17 requests back-to-back with QUEUE_DEPTH=16 → req_ready drops after the 16th; the 17th is held until the first done pulse, then accepted; queue_count never exceeds 16.
- Idle with bank 2 open until the refresh timer expires → PREA, REF 3 cycles later, refresh_busy high throughout, next request needs ACT0. With all banks closed → REF only.
- Assert reset_n during RCD_WAIT with 3 queued → cmd NOP, queue_count 0, req_ready 1 the same cycle; the next request issues ACT0.
